// File: rtl/decode_stage.sv
// decode_stage: instruction decode with operand bypass, load-use stall and ID/EX register.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_if_valid, i_if_instr, o_id_ready   fetch handshake
//   o_rreg1, o_rreg2, i_rd1, i_rd2       register-file read port
//   i_wb_write, i_wb_wreg, i_wb_data     writeback port (bypass source)
//   i_flush, i_ex_ready                  squash and execute-stage handshake
//   o_ex_*                               registered ID/EX contents
module decode_stage (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_if_valid,
   input  logic [15:0] i_if_instr,
   output logic        o_id_ready,
   output logic [2:0]  o_rreg1,
   output logic [2:0]  o_rreg2,
   input  logic [15:0] i_rd1,
   input  logic [15:0] i_rd2,
   input  logic        i_wb_write,
   input  logic [2:0]  i_wb_wreg,
   input  logic [15:0] i_wb_data,
   input  logic        i_flush,
   input  logic        i_ex_ready,
   output logic        o_ex_valid,
   output logic [3:0]  o_ex_op,
   output logic [15:0] o_ex_a,
   output logic [15:0] o_ex_b,
   output logic [15:0] o_ex_imm,
   output logic [2:0]  o_ex_wreg,
   output logic        o_ex_regwrite,
   output logic        o_ex_memread,
   output logic        o_ex_memwrite,
   output logic        o_ex_branch
);
   logic [3:0]  w_op;
   logic [2:0]  w_rs, w_rt, w_rd, w_wreg;
   logic        w_use_rs, w_use_rt, w_regwrite, w_memread, w_memwrite, w_branch;
   logic [15:0] w_a, w_b, w_imm;
   logic        w_hazard, w_advance, w_load, w_clear;
   logic        r_valid, r_regwrite, r_memread, r_memwrite, r_branch;
   logic [3:0]  r_op;
   logic [15:0] r_a, r_b, r_imm;
   logic [2:0]  r_wreg;

   assign w_op = i_if_instr[15:12];
   assign w_rs = i_if_instr[11:9];
   assign w_rt = i_if_instr[8:6];
   assign w_rd = i_if_instr[5:3];
   assign o_rreg1 = w_rs;
   assign o_rreg2 = w_rt;

   // ops 0..A read rs; only R-ALU, SW and BEQ also read rt; B..F are NOPs
   assign w_use_rs   = w_op <= 4'hA;
   assign w_use_rt   = w_op == 4'h0 || w_op == 4'h9 || w_op == 4'hA;
   assign w_regwrite = w_op <= 4'h8;
   assign w_memread  = w_op == 4'h8;
   assign w_memwrite = w_op == 4'h9;
   assign w_branch   = w_op == 4'hA;
   assign w_wreg     = w_op == 4'h0 ? w_rd : (w_regwrite ? w_rt : 3'd0);
   assign w_imm      = {{10{i_if_instr[5]}}, i_if_instr[5:0]};

   // writeback bypass: the register file commits this write at the same edge
   assign w_a = !w_use_rs ? 16'd0 : (i_wb_write && i_wb_wreg == w_rs) ? i_wb_data : i_rd1;
   assign w_b = !w_use_rt ? 16'd0 : (i_wb_write && i_wb_wreg == w_rt) ? i_wb_data : i_rd2;

   // stall only on sources the instruction actually reads
   assign w_hazard = r_valid && r_memread && i_if_valid &&
                     ((w_use_rs && r_wreg == w_rs) || (w_use_rt && r_wreg == w_rt));
   assign w_advance = !r_valid || i_ex_ready;
   assign o_id_ready = !i_rst && (i_flush || (w_advance && !w_hazard));

   assign w_load  = w_advance && i_if_valid && !w_hazard;
   assign w_clear = i_rst || i_flush || (w_advance && !w_load);

   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         r_valid    <= 1'b0;
         r_op       <= 4'd0;
         r_a        <= 16'd0;
         r_b        <= 16'd0;
         r_imm      <= 16'd0;
         r_wreg     <= 3'd0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_branch   <= 1'b0;
      end else if (w_load) begin
         r_valid    <= 1'b1;
         r_op       <= w_op;
         r_a        <= w_a;
         r_b        <= w_b;
         r_imm      <= w_imm;
         r_wreg     <= w_wreg;
         r_regwrite <= w_regwrite;
         r_memread  <= w_memread;
         r_memwrite <= w_memwrite;
         r_branch   <= w_branch;
      end
   end

   assign o_ex_valid    = r_valid;
   assign o_ex_op       = r_op;
   assign o_ex_a        = r_a;
   assign o_ex_b        = r_b;
   assign o_ex_imm      = r_imm;
   assign o_ex_wreg     = r_wreg;
   assign o_ex_regwrite = r_regwrite;
   assign o_ex_memread  = r_memread;
   assign o_ex_memwrite = r_memwrite;
   assign o_ex_branch   = r_branch;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have no parameters; data width 16, register index width 3, fixed.
REQ-002 clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_instr  in  16  instruction: [15:12] op, [11:9] rs, [8:6] rt, [5:3] rd, [5:0] imm6.
REQ-006 id_ready  out  1  stage accepts if_instr this cycle.
REQ-007 rreg1, rreg2  out  3  register-file read indices, combinationally equal to if_instr rs and rt.
REQ-008 rd1, rd2  in  16  register-file read data, combinational from rreg1/rreg2.
REQ-009 wb_write, wb_wreg, wb_data  in  1/3/16  writeback port, the same write the register file commits at this edge.
REQ-010 flush  in  1  squash ID/EX contents and the incoming instruction.
REQ-011 ex_ready  in  1  execute stage accepts ID/EX contents.
REQ-012 ex_valid  out  1  ID/EX holds a real instruction.
REQ-013 ex_op  out  4;  ex_a, ex_b  out  16;  ex_imm  out  16;  ex_wreg  out  3;  ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each; all registered.

Function
REQ-014 Decode table: op 0 R-ALU reads rs,rt, writes rd; op 1-7 I-ALU reads rs, writes rt; op 8 LW reads rs, writes rt, memread; op 9 SW reads rs,rt, memwrite; op A BEQ reads rs,rt, branch; op B-F NOP, reads none, all control bits 0.
REQ-015 ex_imm SHALL be imm6 sign-extended to 16 bits (bit 5 replicated).
REQ-016 Bypass: a used source operand SHALL take wb_data when wb_write=1 and wb_wreg equals its index, else rd1/rd2; unused operands load 0.
REQ-017 Load-use hazard: hazard=1 when ex_valid, ex_memread=1, and ex_wreg equals a source that if_instr actually uses, with if_valid=1.
REQ-018 advance = !ex_valid || ex_ready.
REQ-019 id_ready = advance && !hazard, or 1 when flush=1.
REQ-020 On advance with if_valid=1, hazard=0, flush=0: ID/EX loads decoded instruction, ex_valid=1 next cycle (latency one cycle).
REQ-021 On advance with hazard=1: ID/EX loads a bubble (ex_valid=0, control bits 0), instruction held in fetch.
REQ-022 On advance with if_valid=0: bubble loaded.
REQ-023 When advance=0 and flush=0: all ID/EX outputs SHALL hold unchanged (no drop, no duplicate).
REQ-024 flush=1 SHALL have priority over all: next cycle ex_valid=0, control bits 0; a presented instruction is consumed and discarded.
REQ-025 Bubbles SHALL carry ex_regwrite=ex_memread=ex_memwrite=ex_branch=0; data fields are don't-care but SHALL be driven to 0.
REQ-026 Writes to index 0 are ordinary; no hardwired-zero register.
REQ-027 Hazard with NOP or unused-source match SHALL NOT stall (e.g. I-ALU rt field matching load target).

Reset
REQ-028 reset=1 SHALL clear ex_valid and every ex_* output to 0 at the next edge, overriding flush and handshake.
REQ-029 During reset id_ready SHALL be 0; first acceptance possible in the cycle after reset deasserts.
REQ-030 Reset mid-stall SHALL discard pending hazard state; no internal state beyond ID/EX registers.

Verification
REQ-031 R-ALU 0x0A50 (rs=5, rt=1, rd=2), rd1=0x1234, rd2=0x0042, ex_ready=1 -> next cycle ex_valid=1, ex_a=0x1234, ex_b=0x0042, ex_wreg=2, ex_regwrite=1.
REQ-032 LW writing r3 in ID/EX, then R-ALU reading rs=3 -> id_ready=0 one cycle, bubble inserted, instruction accepted the following cycle.
REQ-033 wb_write=1, wb_wreg=4, wb_data=0xBEEF while rs=4, rd1=0x0000 -> ex_a=0xBEEF.
REQ-034 ex_ready=0 for 3 cycles with if_valid=1 -> ex_* stable, id_ready=0; release -> next instruction accepted exactly once.
REQ-035 flush=1 with valid ID/EX and if_valid=1 -> id_ready=1, next cycle ex_valid=0, all control bits 0.
REQ-036 I-ALU imm6=0x3F -> ex_imm=0xFFFF; imm6=0x1F -> ex_imm=0x001F; reset asserted mid-operation -> all ex_* 0 next edge.
